// File: rtl/branch_pc_unit.sv
// Program counter / fetch-address stage with IDLE/RUN/HALT control and a loadable absolute branch-target table.
// Optional macro BRANCH_PC_TRACE_EN adds a saturating taken-branch counter on TakenCount.
module branch_pc_unit #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16,
  parameter int LUT_AW    = 4
)(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              Branch,
  input  logic              takeBranch,
  input  logic              BranchAbs,
  input  logic [LUT_AW-1:0] TargetIdx,
  input  logic [7:0]        RelOffset,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic [PC_W-1:0]   InstAddr,
  output logic              Running,
  output logic              Done,
  output logic [15:0]       TakenCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [PC_W-1:0] r_lut [LUT_DEPTH];
  logic [PC_W-1:0] w_rel_tgt;

  // Offset is sign-extended to PC_W (assumes PC_W >= 8); the add wraps modulo 2^PC_W.
  assign w_rel_tgt = r_pc + {{(PC_W-8){RelOffset[7]}}, RelOffset};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = '0;
        end
      end
      ST_RUN: begin
        if (!Stall) begin
          if (Halt)
            w_state_nxt = ST_HALT;
          else if (Branch && takeBranch)
            w_pc_nxt = BranchAbs ? r_lut[TargetIdx] : w_rel_tgt;
          else
            w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Table is never cleared; a same-cycle branch read sees the pre-write entry.
  always_ff @(posedge Clk) begin
    if (LutWe)
      r_lut[LutAddr] <= LutData;
  end

  assign InstAddr = r_pc;
  assign Running  = (r_state == ST_RUN);
  assign Done     = (r_state == ST_HALT);

`ifdef BRANCH_PC_TRACE_EN
  logic        w_taken, w_launch;
  logic [15:0] r_taken_cnt;

  assign w_taken  = (r_state == ST_RUN) && !Stall && !Halt && Branch && takeBranch;
  assign w_launch = (r_state != ST_RUN) && Start;

  always_ff @(posedge Clk) begin
    if (Reset || w_launch)
      r_taken_cnt <= '0;
    else if (w_taken && (r_taken_cnt != 16'hFFFF))
      r_taken_cnt <= r_taken_cnt + 16'd1;
  end

  assign TakenCount = r_taken_cnt;
`else
  assign TakenCount = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed + randomized bench for branch_pc_unit against a behavioural PC/state model.
module tb_branch_pc_unit;
  localparam int PC_W = 10, LUT_DEPTH = 16, LUT_AW = 4;
  localparam int PC_MASK = (1 << PC_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset, Start, Stall, Halt, Branch, takeBranch, BranchAbs, LutWe;
  logic [LUT_AW-1:0] TargetIdx, LutAddr;
  logic [7:0]        RelOffset;
  logic [PC_W-1:0]   LutData;
  logic [PC_W-1:0]   InstAddr;
  logic              Running, Done;
  logic [15:0]       TakenCount;

  branch_pc_unit #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH), .LUT_AW(LUT_AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .Branch(Branch), .takeBranch(takeBranch), .BranchAbs(BranchAbs),
    .TargetIdx(TargetIdx), .RelOffset(RelOffset), .LutWe(LutWe),
    .LutAddr(LutAddr), .LutData(LutData), .InstAddr(InstAddr),
    .Running(Running), .Done(Done), .TakenCount(TakenCount)
  );

  always #5 Clk = ~Clk;

  // Model: mode 0=idle 1=run 2=halt
  int m_mode, m_pc, m_cnt;
  int m_lut [LUT_DEPTH];
  int n_tests = 0, n_fail = 0;

  function automatic int exp_cnt();
`ifdef BRANCH_PC_TRACE_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    int off;
    off = int'($signed(RelOffset));
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0;
    end else if (m_mode != 1) begin
      if (Start) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
    end else if (!Stall) begin
      if (Halt) m_mode = 2;
      else if (Branch && takeBranch) begin
        m_pc  = BranchAbs ? m_lut[TargetIdx] : ((m_pc + off) & PC_MASK);
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else m_pc = (m_pc + 1) & PC_MASK;
    end
    if (LutWe) m_lut[LutAddr] = int'(LutData);
  endtask

  task automatic check(input string tag);
    n_tests++;
    assert (InstAddr === PC_W'(m_pc)) else begin
      n_fail++; $error("FAIL %s InstAddr got %0h exp %0h", tag, InstAddr, m_pc);
    end
    n_tests++;
    assert (Running === (m_mode == 1)) else begin
      n_fail++; $error("FAIL %s Running got %0b exp %0b", tag, Running, m_mode == 1);
    end
    n_tests++;
    assert (Done === (m_mode == 2)) else begin
      n_fail++; $error("FAIL %s Done got %0b exp %0b", tag, Done, m_mode == 2);
    end
    n_tests++;
    assert (TakenCount === 16'(exp_cnt())) else begin
      n_fail++; $error("FAIL %s TakenCount got %0d exp %0d", tag, TakenCount, exp_cnt());
    end
  endtask

  task automatic check_pc(input string tag, input int exp);
    n_tests++;
    assert (InstAddr === PC_W'(exp)) else begin
      n_fail++; $error("FAIL %s const InstAddr got %0h exp %0h", tag, InstAddr, exp);
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge Clk); #1;
    check(tag);
  endtask

  task automatic clr_in();
    Reset = 0; Start = 0; Stall = 0; Halt = 0; Branch = 0; takeBranch = 0;
    BranchAbs = 0; TargetIdx = '0; RelOffset = '0; LutWe = 0; LutAddr = '0; LutData = '0;
  endtask

  task automatic br(input logic tk, input logic ab, input int idx, input int off);
    Branch = 1; takeBranch = tk; BranchAbs = ab;
    TargetIdx = LUT_AW'(idx); RelOffset = 8'(off);
  endtask

  initial begin
    clr_in();
    m_mode = 0; m_pc = 0; m_cnt = 0;
    @(negedge Clk);
    // Load whole table while reset is held
    Reset = 1;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      LutWe = 1; LutAddr = LUT_AW'(i); LutData = PC_W'($urandom);
      if (i == 2) LutData = 10'h120;
      if (i == 7) LutData = 10'h011;
      tick("reset");
    end
    clr_in();
    check_pc("reset_pc", 0);

    // Start then sequential fetch 0..5
    Start = 1; tick("start"); Start = 0;
    check_pc("start_pc", 0);
    for (int i = 1; i <= 5; i++) tick("seq");
    check_pc("seq_pc5", 5);
    br(1, 1, 2, 0); tick("abs_taken"); clr_in();
    check_pc("abs_taken", 10'h120);
    br(0, 1, 2, 0); tick("abs_not_taken"); clr_in();
    check_pc("abs_not_taken", 10'h121);
    takeBranch = 1; tick("tb_no_branch"); clr_in();

    // Restart, relative wrap backwards then increment wrap
    Halt = 1; tick("halt"); clr_in();
    Start = 1; tick("restart"); clr_in();
    for (int i = 0; i < 3; i++) tick("seq2");
    br(1, 0, 0, 8'hFB); tick("rel_neg_wrap"); clr_in();
    check_pc("rel_neg_wrap", 10'h3FE);
    tick("inc"); check_pc("inc_3ff", 10'h3FF);
    tick("inc_wrap"); check_pc("inc_wrap", 0);

    // Stall dominates halt and branch
    for (int i = 0; i < 3; i++) begin
      Stall = 1; Halt = 1; br(1, 0, 0, 8'h40); tick("stall");
    end
    clr_in(); Halt = 1; tick("halt_after_stall");
    clr_in(); tick("halt_hold"); Start = 0; tick("halt_hold2");
    Start = 1; tick("halt_start"); clr_in();
    check_pc("halt_start", 0);

    // Same-cycle write vs read of table entry 7
    LutWe = 1; LutAddr = 4'd7; LutData = 10'h055; br(1, 1, 7, 0);
    tick("lut_old"); clr_in();
    check_pc("lut_old", 10'h011);
    br(1, 1, 7, 0); tick("lut_new"); clr_in();
    check_pc("lut_new", 10'h055);

    // Taken-branch counting, then reset mid-run
    Halt = 1; tick("h"); clr_in(); Start = 1; tick("s"); clr_in();
    for (int i = 0; i < 3; i++) begin br(1, 0, 0, 2); tick("cnt_taken"); end
    for (int i = 0; i < 2; i++) begin br(0, 0, 0, 2); tick("cnt_nt"); end
    br(1, 0, 0, 2); Stall = 1; tick("cnt_stall"); clr_in();
    n_tests++;
`ifdef BRANCH_PC_TRACE_EN
    assert (TakenCount === 16'd3) else begin
      n_fail++; $error("FAIL cnt3 TakenCount got %0d exp 3", TakenCount);
    end
`else
    assert (TakenCount === 16'd0) else begin
      n_fail++; $error("FAIL cnt0 TakenCount got %0d exp 0", TakenCount);
    end
`endif
    Reset = 1; br(1, 0, 0, 9); tick("reset_mid_run"); clr_in();
    check_pc("reset_mid_run", 0);

    // Randomized run
    for (int c = 0; c < 2000; c++) begin
      Reset      = ($urandom_range(0, 59) == 0);
      Start      = ($urandom_range(0, 9) == 0);
      Stall      = ($urandom_range(0, 4) == 0);
      Halt       = ($urandom_range(0, 29) == 0);
      Branch     = ($urandom_range(0, 2) == 0);
      takeBranch = 1'($urandom);
      BranchAbs  = 1'($urandom);
      TargetIdx  = LUT_AW'($urandom);
      RelOffset  = 8'($urandom);
      LutWe      = ($urandom_range(0, 3) == 0);
      LutAddr    = LUT_AW'($urandom);
      LutData    = PC_W'($urandom);
      tick("rand");
    end
    clr_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
